// File: rtl/fpalu_sequencer.sv
// Multi-cycle issue controller for the FPALU: holds opcode/operands stable for the
// opcode's latency, then captures result and flags and pulses odone for one cycle.
module fpalu_sequencer #(
  parameter int unsigned LAT_ADDSUB = 8,
  parameter int unsigned LAT_MUL    = 6,
  parameter int unsigned LAT_DIV    = 7,
  parameter int unsigned LAT_SQRT   = 17,
  parameter int unsigned LAT_CMP    = 2,
  parameter int unsigned LAT_CVT    = 7,
  parameter int unsigned LAT_MINMAX = 2,
  parameter int unsigned LAT_COMB   = 1
) (
  input  logic        iclock,
  input  logic        ireset,
  input  logic        istart,
  input  logic        iabort,
  input  logic [4:0]  icontrol,
  input  logic [31:0] idataa,
  input  logic [31:0] idatab,
  output logic [4:0]  ofpu_control,
  output logic [31:0] ofpu_dataa,
  output logic [31:0] ofpu_datab,
  input  logic [31:0] ifpu_result,
  input  logic        ifpu_nan,
  input  logic        ifpu_zero,
  input  logic        ifpu_overflow,
  input  logic        ifpu_underflow,
  input  logic        ifpu_comp,
  output logic        obusy,
  output logic        odone,
  output logic [31:0] oresult,
  output logic        onan,
  output logic        ozero,
  output logic        ooverflow,
  output logic        ounderflow,
  output logic        oCompResult
);

  // Opcode encodings shared with the core's FP opcode table
  localparam logic [4:0] FOPADD    = 5'd0;
  localparam logic [4:0] FOPSUB    = 5'd1;
  localparam logic [4:0] FOPMUL    = 5'd2;
  localparam logic [4:0] FOPDIV    = 5'd3;
  localparam logic [4:0] FOPSQRT   = 5'd4;
  localparam logic [4:0] FOPABS    = 5'd5;
  localparam logic [4:0] FOPNEG    = 5'd6;
  localparam logic [4:0] FOPCEQ    = 5'd7;
  localparam logic [4:0] FOPCLT    = 5'd8;
  localparam logic [4:0] FOPCLE    = 5'd9;
  localparam logic [4:0] FOPCVTSW  = 5'd10;
  localparam logic [4:0] FOPCVTWS  = 5'd11;
  localparam logic [4:0] FOPSGNJ   = 5'd12;
  localparam logic [4:0] FOPSGNJN  = 5'd13;
  localparam logic [4:0] FOPSGNJX  = 5'd14;
  localparam logic [4:0] FOPMAX    = 5'd15;
  localparam logic [4:0] FOPMIN    = 5'd16;
  localparam logic [4:0] FOPCVTSWU = 5'd17;
  localparam logic [4:0] FOPCVTWUS = 5'd18;

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [4:0]  lat_sel;
  logic        accept, capture;
  logic        done_reg;
  logic [4:0]  ctrl_reg;
  logic [31:0] dataa_reg, datab_reg, result_reg;
  logic [4:0]  flags_reg;  // {comp, nan, zero, overflow, underflow}

  always_comb begin
    lat_sel = 5'(LAT_COMB);
    case (icontrol)
      FOPADD, FOPSUB:                             lat_sel = 5'(LAT_ADDSUB);
      FOPMUL:                                     lat_sel = 5'(LAT_MUL);
      FOPDIV:                                     lat_sel = 5'(LAT_DIV);
      FOPSQRT:                                    lat_sel = 5'(LAT_SQRT);
      FOPCEQ, FOPCLT, FOPCLE:                     lat_sel = 5'(LAT_CMP);
      FOPCVTSW, FOPCVTWS, FOPCVTSWU, FOPCVTWUS:   lat_sel = 5'(LAT_CVT);
      FOPMAX, FOPMIN:                             lat_sel = 5'(LAT_MINMAX);
      FOPABS, FOPNEG, FOPSGNJ, FOPSGNJN, FOPSGNJX: lat_sel = 5'(LAT_COMB);
      default:                                    lat_sel = 5'(LAT_COMB);
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (istart && !iabort) begin
          accept     = 1'b1;
          cnt_next   = lat_sel;
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        // Abort outranks the final-cycle capture
        if (iabort) begin
          cnt_next   = 5'd0;
          state_next = S_IDLE;
        end else if (cnt_reg <= 5'd1) begin
          capture    = 1'b1;
          cnt_next   = 5'd0;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg - 5'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 5'd0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= capture;
    end
  end

  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset) begin
      ctrl_reg  <= 5'd0;
      dataa_reg <= 32'd0;
      datab_reg <= 32'd0;
    end else if (accept) begin
      ctrl_reg  <= icontrol;
      dataa_reg <= idataa;
      datab_reg <= idatab;
    end
  end

  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset) begin
      result_reg <= 32'd0;
      flags_reg  <= 5'd0;
    end else if (capture) begin
      result_reg <= ifpu_result;
      flags_reg  <= {ifpu_comp, ifpu_nan, ifpu_zero, ifpu_overflow, ifpu_underflow};
    end
  end

  assign ofpu_control = ctrl_reg;
  assign ofpu_dataa   = dataa_reg;
  assign ofpu_datab   = datab_reg;
  assign obusy        = (state_reg == S_EXEC);
  assign odone        = done_reg;
  assign oresult      = result_reg;
  assign oCompResult  = flags_reg[4];
  assign onan         = flags_reg[3];
  assign ozero        = flags_reg[2];
  assign ooverflow    = flags_reg[1];
  assign ounderflow   = flags_reg[0];

endmodule

// File: tb/tb_fpalu_sequencer.sv
// Bench for fpalu_sequencer: a stand-in FPALU feeds results back, and a
// transaction-level model predicts latency, capture value and flags.
module tb_fpalu_sequencer;

  localparam logic [4:0] FOPADD    = 5'd0;
  localparam logic [4:0] FOPSUB    = 5'd1;
  localparam logic [4:0] FOPMUL    = 5'd2;
  localparam logic [4:0] FOPDIV    = 5'd3;
  localparam logic [4:0] FOPSQRT   = 5'd4;
  localparam logic [4:0] FOPABS    = 5'd5;
  localparam logic [4:0] FOPNEG    = 5'd6;
  localparam logic [4:0] FOPCEQ    = 5'd7;
  localparam logic [4:0] FOPCLT    = 5'd8;
  localparam logic [4:0] FOPCLE    = 5'd9;
  localparam logic [4:0] FOPCVTSW  = 5'd10;
  localparam logic [4:0] FOPCVTWS  = 5'd11;
  localparam logic [4:0] FOPSGNJ   = 5'd12;
  localparam logic [4:0] FOPSGNJN  = 5'd13;
  localparam logic [4:0] FOPSGNJX  = 5'd14;
  localparam logic [4:0] FOPMAX    = 5'd15;
  localparam logic [4:0] FOPMIN    = 5'd16;
  localparam logic [4:0] FOPCVTSWU = 5'd17;
  localparam logic [4:0] FOPCVTWUS = 5'd18;

  logic        iclock = 1'b0;
  logic        ireset, istart, iabort;
  logic [4:0]  icontrol;
  logic [31:0] idataa, idatab;
  logic [4:0]  ofpu_control;
  logic [31:0] ofpu_dataa, ofpu_datab;
  logic [31:0] ifpu_result;
  logic        ifpu_nan, ifpu_zero, ifpu_overflow, ifpu_underflow, ifpu_comp;
  logic        obusy, odone;
  logic [31:0] oresult;
  logic        onan, ozero, ooverflow, ounderflow, oCompResult;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          scramble = 1'b0;
  logic [31:0] exp_last = 32'h0;
  logic [36:0] fpu_bus, obus;

  fpalu_sequencer dut (
    .iclock(iclock), .ireset(ireset), .istart(istart), .iabort(iabort),
    .icontrol(icontrol), .idataa(idataa), .idatab(idatab),
    .ofpu_control(ofpu_control), .ofpu_dataa(ofpu_dataa), .ofpu_datab(ofpu_datab),
    .ifpu_result(ifpu_result), .ifpu_nan(ifpu_nan), .ifpu_zero(ifpu_zero),
    .ifpu_overflow(ifpu_overflow), .ifpu_underflow(ifpu_underflow), .ifpu_comp(ifpu_comp),
    .obusy(obusy), .odone(odone), .oresult(oresult), .onan(onan), .ozero(ozero),
    .ooverflow(ooverflow), .ounderflow(ounderflow), .oCompResult(oCompResult)
  );

  always #5 iclock = ~iclock;
  always @(posedge iclock) cyc <= cyc + 1;

  // Latency table, one entry per opcode group
  function automatic int ref_lat(input logic [4:0] op);
    case (op)
      FOPADD, FOPSUB:                           return 8;
      FOPMUL:                                   return 6;
      FOPDIV:                                   return 7;
      FOPSQRT:                                  return 17;
      FOPCEQ, FOPCLT, FOPCLE:                   return 2;
      FOPCVTSW, FOPCVTWS, FOPCVTSWU, FOPCVTWUS: return 7;
      FOPMAX, FOPMIN:                           return 2;
      default:                                  return 1;
    endcase
  endfunction

  // Stand-in FPALU: {comp, nan, zero, ovf, unf, result}; in scramble mode the
  // output also depends on the cycle, so a capture on the wrong edge shows up.
  function automatic logic [36:0] fake_fpalu(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input int c, input bit scr);
    logic [31:0] r, h;
    logic        cmp;
    r   = 32'h0;
    cmp = 1'b0;
    case (op)
      FOPADD:  r = (a == 32'h3FC00000 && b == 32'h40100000) ? 32'h40700000 : a + b;
      FOPSUB:  r = a - b;
      FOPMUL:  r = (a == 32'h40000000 && b == 32'h40400000) ? 32'h40C00000 : a ^ b;
      FOPDIV:  r = a ^ ~b;
      FOPSQRT: r = (a == 32'h40800000) ? 32'h40000000 : a >> 1;
      FOPNEG:  r = a ^ 32'h80000000;
      FOPABS:  r = a & 32'h7FFFFFFF;
      FOPCEQ:  cmp = (a == b);
      FOPCLT:  cmp = (a < b);
      FOPCLE:  cmp = (a <= b);
      default: r = 32'h0;
    endcase
    h = scr ? 32'(c) * 32'h9E3779B1 : 32'h0;
    return {cmp ^ h[31], h[30:27], r ^ h};
  endfunction

  always_comb fpu_bus = fake_fpalu(ofpu_control, ofpu_dataa, ofpu_datab, cyc, scramble);
  assign {ifpu_comp, ifpu_nan, ifpu_zero, ifpu_overflow, ifpu_underflow, ifpu_result} = fpu_bus;
  assign obus = {oCompResult, onan, ozero, ooverflow, ounderflow, oresult};

  task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int c0);
    istart = 1'b1; icontrol = op; idataa = a; idatab = b;
    c0 = cyc;
    @(posedge iclock); #1;
  endtask

  // Edges from accept until odone is seen, and how many of those cycles were busy
  task automatic wait_done(output int edges, output int busy_n);
    edges = 0; busy_n = 0;
    while (odone !== 1'b1 && edges < 40) begin
      if (obusy === 1'b1) busy_n++;
      @(posedge iclock); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    ireset = 1'b1; istart = 1'b0; iabort = 1'b0;
    icontrol = 5'd0; idataa = 32'd0; idatab = 32'd0;
    repeat (3) @(posedge iclock);
    #1;
    total++;
    if ({obusy, odone} !== 2'b00) begin
      bad++; $display("FAIL reset_busy_done got=%b exp=00", {obusy, odone});
    end
    total++;
    if ({ofpu_control, ofpu_dataa, ofpu_datab} !== 69'd0) begin
      bad++; $display("FAIL reset_fpu_regs got=%h exp=0", {ofpu_control, ofpu_dataa, ofpu_datab});
    end
    total++;
    if (obus !== 37'd0) begin
      bad++; $display("FAIL reset_result got=%h exp=0", obus);
    end
    ireset = 1'b0;
    @(posedge iclock); #1;
    $display("reset: outputs cleared");
  endtask

  task automatic test_add();
    int c0, n, bn;
    start_op(FOPADD, 32'h3FC00000, 32'h40100000, c0);
    istart = 1'b0;
    wait_done(n, bn);
    total++;
    if (n != 8) begin bad++; $display("FAIL add_latency got=%0d exp=8", n); end
    total++;
    if (bn != 8) begin bad++; $display("FAIL add_busy_cycles got=%0d exp=8", bn); end
    total++;
    if (obus !== {5'b0, 32'h40700000}) begin
      bad++; $display("FAIL add_result got=%h exp=%h", obus, {5'b0, 32'h40700000});
    end
    total++;
    if (obusy !== 1'b0) begin bad++; $display("FAIL add_busy_in_done got=%b exp=0", obusy); end
    exp_last = 32'h40700000;
    @(posedge iclock); #1;
    total++;
    if (odone !== 1'b0) begin bad++; $display("FAIL add_done_width got=%b exp=0", odone); end
    $display("add: latency=%0d result=%h", n, oresult);
  endtask

  task automatic test_back_to_back();
    int c0, n, bn;
    start_op(FOPMUL, 32'h40000000, 32'h40400000, c0);
    istart = 1'b0;
    wait_done(n, bn);
    total++;
    if (n != 6) begin bad++; $display("FAIL mul_latency got=%0d exp=6", n); end
    total++;
    if (oresult !== 32'h40C00000) begin
      bad++; $display("FAIL mul_result got=%h exp=40c00000", oresult);
    end
    $display("mul: latency=%0d result=%h", n, oresult);
    start_op(FOPSQRT, 32'h40800000, 32'h0, c0);
    istart = 1'b0;
    total++;
    if (obusy !== 1'b1 || ofpu_control !== FOPSQRT) begin
      bad++; $display("FAIL sqrt_accept_in_done got=%b/%0d exp=1/%0d", obusy, ofpu_control, FOPSQRT);
    end
    wait_done(n, bn);
    total++;
    if (n != 17) begin bad++; $display("FAIL sqrt_latency got=%0d exp=17", n); end
    total++;
    if (oresult !== 32'h40000000) begin
      bad++; $display("FAIL sqrt_result got=%h exp=40000000", oresult);
    end
    exp_last = 32'h40000000;
    $display("sqrt: latency=%0d result=%h", n, oresult);
  endtask

  task automatic test_compare();
    int c0, n, bn;
    logic [31:0] av[2];
    logic [31:0] bv[2];
    logic        ev[2];
    av[0] = 32'h3F800000; bv[0] = 32'h40000000; ev[0] = 1'b1;
    av[1] = 32'h40000000; bv[1] = 32'h3F800000; ev[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start_op(FOPCLT, av[k], bv[k], c0);
      istart = 1'b0;
      wait_done(n, bn);
      total++;
      if (n != 2) begin bad++; $display("FAIL clt_latency[%0d] got=%0d exp=2", k, n); end
      total++;
      if (oCompResult !== ev[k]) begin
        bad++; $display("FAIL clt_comp[%0d] got=%b exp=%b", k, oCompResult, ev[k]);
      end
      $display("clt: a=%h b=%h comp=%b", av[k], bv[k], oCompResult);
    end
    exp_last = 32'h0;
  endtask

  task automatic test_neg_held();
    int c0, n, bn;
    logic [31:0] av[3];
    av[0] = 32'h3F800000; av[1] = 32'h40000000; av[2] = 32'hC0400000;
    start_op(FOPNEG, av[0], 32'h0, c0);
    for (int k = 0; k < 3; k++) begin
      wait_done(n, bn);
      total++;
      if (n != 1) begin bad++; $display("FAIL neg_latency[%0d] got=%0d exp=1", k, n); end
      total++;
      if (oresult !== (av[k] ^ 32'h80000000)) begin
        bad++; $display("FAIL neg_result[%0d] got=%h exp=%h", k, oresult, av[k] ^ 32'h80000000);
      end
      $display("neg: a=%h result=%h", av[k], oresult);
      if (k < 2) begin
        idataa = av[k+1];
        @(posedge iclock); #1;
      end else begin
        istart = 1'b0;
      end
    end
    exp_last = av[2] ^ 32'h80000000;
  endtask

  task automatic test_abort_div();
    int c0;
    bit seen;
    start_op(FOPDIV, 32'h12345678, 32'h0F0F0F0F, c0);
    istart = 1'b0;
    repeat (2) begin @(posedge iclock); #1; end
    start_op(FOPNEG, 32'h11111111, 32'h0, c0);
    istart = 1'b0;
    iabort = 1'b1;
    @(posedge iclock); #1;
    iabort = 1'b0;
    total++;
    if (ofpu_control !== FOPDIV || ofpu_dataa !== 32'h12345678) begin
      bad++; $display("FAIL div_midop_start got=%0d/%h exp=%0d/12345678", ofpu_control, ofpu_dataa, FOPDIV);
    end
    total++;
    if (obusy !== 1'b0) begin bad++; $display("FAIL div_abort_busy got=%b exp=0", obusy); end
    seen = 1'b0;
    repeat (12) begin
      if (odone === 1'b1) seen = 1'b1;
      @(posedge iclock); #1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL div_abort_done got=1 exp=0"); end
    total++;
    if (oresult !== exp_last) begin
      bad++; $display("FAIL div_abort_result got=%h exp=%h", oresult, exp_last);
    end
    $display("div abort: busy=%b result=%h", obusy, oresult);
  endtask

  task automatic test_abort_last_cycle();
    int c0;
    start_op(FOPMAX, 32'h40000000, 32'h3F800000, c0);
    istart = 1'b0;
    @(posedge iclock); #1;
    iabort = 1'b1;
    @(posedge iclock); #1;
    iabort = 1'b0;
    total++;
    if ({obusy, odone} !== 2'b00) begin
      bad++; $display("FAIL abort_last_state got=%b exp=00", {obusy, odone});
    end
    @(posedge iclock); #1;
    total++;
    if (odone !== 1'b0 || oresult !== exp_last) begin
      bad++; $display("FAIL abort_last_result got=%b/%h exp=0/%h", odone, oresult, exp_last);
    end
    $display("abort on last cycle: done=%b result=%h", odone, oresult);
  endtask

  task automatic test_async_reset();
    int c0, n, bn;
    bit seen;
    start_op(FOPSQRT, 32'h40800000, 32'h0, c0);
    istart = 1'b0;
    repeat (8) begin @(posedge iclock); #1; end
    #3 ireset = 1'b1;
    #1;
    total++;
    if ({obusy, odone, ofpu_control, ofpu_dataa, ofpu_datab, obus} !== 108'd0) begin
      bad++; $display("FAIL async_reset_outputs got=%b%b/%h/%h exp=0", obusy, odone, ofpu_control, obus);
    end
    #2 ireset = 1'b0;
    exp_last = 32'h0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge iclock); #1;
      if (odone === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL async_reset_done got=1 exp=0"); end
    start_op(FOPADD, 32'h3FC00000, 32'h40100000, c0);
    istart = 1'b0;
    wait_done(n, bn);
    total++;
    if (n != 8 || oresult !== 32'h40700000) begin
      bad++; $display("FAIL post_reset_add got=%0d/%h exp=8/40700000", n, oresult);
    end
    exp_last = 32'h40700000;
    $display("async reset then add: latency=%0d result=%h", n, oresult);
  endtask

  task automatic test_random();
    int c0, n, bn, lat;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [36:0] exp;
    scramble = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 31));
      a  = $urandom;
      b  = $urandom;
      lat = ref_lat(op);
      start_op(op, a, b, c0);
      istart = 1'b0;
      wait_done(n, bn);
      exp = fake_fpalu(op, a, b, c0 + lat, 1'b1);
      total++;
      if (n != lat || bn != lat) begin
        bad++; $display("FAIL rand_latency[%0d] op=%0d got=%0d/%0d exp=%0d", i, op, n, bn, lat);
      end
      total++;
      if (obus !== exp) begin
        bad++; $display("FAIL rand_result[%0d] op=%0d got=%h exp=%h", i, op, obus, exp);
      end
      total++;
      if (ofpu_control !== op || ofpu_dataa !== a || ofpu_datab !== b || obusy !== 1'b0) begin
        bad++; $display("FAIL rand_fpu_hold[%0d] got=%0d/%h/%h exp=%0d/%h/%h", i, ofpu_control, ofpu_dataa, ofpu_datab, op, a, b);
      end
      $display("rand %0d: op=%0d lat=%0d result=%h", i, op, n, oresult);
      exp_last = exp[31:0];
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) begin @(posedge iclock); #1; end
      end
    end
    scramble = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_compare();
    test_neg_held();
    test_abort_div();
    test_abort_last_cycle();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
